// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared definitions for the multi-bank register file.
// Holds the default parameter values, the clear-sequencer state encoding
// and a bank-legality helper used by both the storage and the sequencer.
package reg_file_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_BANKS_DEF  = 2;
  localparam int BANK_W_DEF     = 1;
  localparam int BYPASS_DEF     = 1;
  localparam int ZERO_REG0_DEF  = 1;

  // Bulk-clear sequencer states.
  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  // A bank select is legal only when it names an existing bank; BANK_W may
  // be wider than needed, so out-of-range codes must be filtered explicitly.
  function automatic logic bank_legal(input int unsigned bank,
                                      input int unsigned num_banks);
    return (bank < num_banks);
  endfunction

endpackage

// File: rtl/reg_clr_seq.sv
// reg_clr_seq: bulk-clear sequencer for reg_file_mb.
// Walks a counter over every entry of one latched bank, one entry per cycle,
// then pulses done for one cycle.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_clr_req           clear request (ignored while busy or bank illegal)
//   i_clr_bank          bank to clear
//   o_busy              high in CLEAR and DONE (DEPTH+1 cycles)
//   o_done              one-cycle pulse in DONE
//   o_clr_en            an entry is zeroed at the next rising edge
//   o_clr_addr          entry being zeroed
//   o_clr_bank          latched bank being cleared
module reg_clr_seq
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BANK_W     = BANK_W_DEF,
  parameter int NUM_BANKS  = NUM_BANKS_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr_req,
  input  logic [BANK_W-1:0]     i_clr_bank,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_clr_en,
  output logic [ADDR_WIDTH-1:0] o_clr_addr,
  output logic [BANK_W-1:0]     o_clr_bank
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  clr_state_e            state_r;
  clr_state_e            state_nxt_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] cnt_nxt_s;
  logic [BANK_W-1:0]     bank_r;
  logic [BANK_W-1:0]     bank_nxt_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  req_ok_s;

  assign req_ok_s = i_clr_req && bank_legal(32'(i_clr_bank), NUM_BANKS);

  // Next-state, counter and bank-latch logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bank_nxt_s  = bank_r;
    case (state_r)
      CLR_IDLE: begin
        if (req_ok_s) begin
          state_nxt_s = CLR_CLEAR;
          cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
          bank_nxt_s  = i_clr_bank;
        end else begin
          state_nxt_s = CLR_IDLE;
        end
      end
      CLR_CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = CLR_DONE;
          cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
        end else begin
          cnt_nxt_s   = cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      CLR_DONE: begin
        state_nxt_s = CLR_IDLE;
      end
      default: begin
        state_nxt_s = CLR_IDLE;
        cnt_nxt_s   = {ADDR_WIDTH{1'b0}};
      end
    endcase
  end

  // State, counter, latched bank and registered status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= CLR_IDLE;
      cnt_r   <= {ADDR_WIDTH{1'b0}};
      bank_r  <= {BANK_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      bank_r  <= bank_nxt_s;
      busy_r  <= (state_nxt_s != CLR_IDLE);
      done_r  <= (state_nxt_s == CLR_DONE);
    end
  end

  assign o_busy     = busy_r;
  assign o_done     = done_r;
  assign o_clr_en   = (state_r == CLR_CLEAR);
  assign o_clr_addr = cnt_r;
  assign o_clr_bank = bank_r;

endmodule

// File: rtl/reg_file_mb.sv
// reg_file_mb: multi-bank register file with two combinational read ports,
// one write port, per-entry pending bits and a bulk bank-clear sequencer.
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_rd_bank_a/b, i_rd_addr_a/b       read port selects
//   o_rd_data_a/b, o_pend_a/b          read data and pending bit (combinational)
//   i_wr_en, i_wr_bank/addr/data       write port
//   i_pend_set, i_pend_bank/addr       mark an entry pending
//   i_clr_req, i_clr_bank              request bulk clear of one bank
//   o_clr_busy, o_clr_done             clear in progress / completion pulse
module reg_file_mb
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int BANK_W     = BANK_W_DEF,
  parameter int BYPASS     = BYPASS_DEF,
  parameter int ZERO_REG0  = ZERO_REG0_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [BANK_W-1:0]     i_rd_bank_a,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_a,
  input  logic [BANK_W-1:0]     i_rd_bank_b,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr_b,
  output logic [DATA_WIDTH-1:0] o_rd_data_a,
  output logic [DATA_WIDTH-1:0] o_rd_data_b,
  output logic                  o_pend_a,
  output logic                  o_pend_b,
  input  logic                  i_wr_en,
  input  logic [BANK_W-1:0]     i_wr_bank,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_pend_set,
  input  logic [BANK_W-1:0]     i_pend_bank,
  input  logic [ADDR_WIDTH-1:0] i_pend_addr,
  input  logic                  i_clr_req,
  input  logic [BANK_W-1:0]     i_clr_bank,
  output logic                  o_clr_busy,
  output logic                  o_clr_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r  [NUM_BANKS][DEPTH];
  logic [DEPTH-1:0]      pend_r [NUM_BANKS];

  logic                  clr_busy_s;
  logic                  clr_done_s;
  logic                  clr_en_s;
  logic [ADDR_WIDTH-1:0] clr_addr_s;
  logic [BANK_W-1:0]     clr_bank_s;

  logic                  wr_ok_s;
  logic                  pend_ok_s;

  logic [BANK_W-1:0]     rd_bank_s [2];
  logic [ADDR_WIDTH-1:0] rd_addr_s [2];
  logic [DATA_WIDTH-1:0] rd_data_s [2];
  logic                  rd_pend_s [2];

  // True for the hardwired-zero entry (bank 0, entry 0) when enabled.
  function automatic logic is_zero_entry(input logic [BANK_W-1:0]     bank,
                                         input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG0 != 0) && (bank == {BANK_W{1'b0}}) &&
           (addr == {ADDR_WIDTH{1'b0}});
  endfunction

  reg_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BANK_W     (BANK_W),
    .NUM_BANKS  (NUM_BANKS)
  ) u_clr_seq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr_req  (i_clr_req),
    .i_clr_bank (i_clr_bank),
    .o_busy     (clr_busy_s),
    .o_done     (clr_done_s),
    .o_clr_en   (clr_en_s),
    .o_clr_addr (clr_addr_s),
    .o_clr_bank (clr_bank_s)
  );

  // Writes and pending-sets are dropped for illegal banks, the zero entry,
  // and the bank currently being cleared (whole busy window, incl. DONE).
  assign wr_ok_s   = i_wr_en && bank_legal(32'(i_wr_bank), NUM_BANKS) &&
                     !is_zero_entry(i_wr_bank, i_wr_addr) &&
                     !(clr_busy_s && (i_wr_bank == clr_bank_s));
  assign pend_ok_s = i_pend_set && bank_legal(32'(i_pend_bank), NUM_BANKS) &&
                     !is_zero_entry(i_pend_bank, i_pend_addr) &&
                     !(clr_busy_s && (i_pend_bank == clr_bank_s));

  // Entry storage and pending bits; clear beats write, pending-set beats write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        pend_r[b] <= {DEPTH{1'b0}};
        for (int d = 0; d < DEPTH; d++) begin
          mem_r[b][d] <= {DATA_WIDTH{1'b0}};
        end
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int d = 0; d < DEPTH; d++) begin
          if (clr_en_s && (clr_bank_s == BANK_W'(b)) &&
              (clr_addr_s == ADDR_WIDTH'(d))) begin
            mem_r[b][d]  <= {DATA_WIDTH{1'b0}};
            pend_r[b][d] <= 1'b0;
          end else begin
            if (wr_ok_s && (i_wr_bank == BANK_W'(b)) &&
                (i_wr_addr == ADDR_WIDTH'(d))) begin
              mem_r[b][d] <= i_wr_data;
            end else begin
              mem_r[b][d] <= mem_r[b][d];
            end
            if (pend_ok_s && (i_pend_bank == BANK_W'(b)) &&
                (i_pend_addr == ADDR_WIDTH'(d))) begin
              pend_r[b][d] <= 1'b1;
            end else if (wr_ok_s && (i_wr_bank == BANK_W'(b)) &&
                         (i_wr_addr == ADDR_WIDTH'(d))) begin
              pend_r[b][d] <= 1'b0;
            end else begin
              pend_r[b][d] <= pend_r[b][d];
            end
          end
        end
      end
    end
  end

  assign rd_bank_s[0] = i_rd_bank_a;
  assign rd_addr_s[0] = i_rd_addr_a;
  assign rd_bank_s[1] = i_rd_bank_b;
  assign rd_addr_s[1] = i_rd_addr_b;

  // Read muxes: an illegal bank matches no loop index and so reads 0.
  // Write forwarding affects data only; pending always comes from storage.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = {DATA_WIDTH{1'b0}};
      rd_pend_s[p] = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_bank_s[p] == BANK_W'(b)) begin
          rd_data_s[p] = mem_r[b][rd_addr_s[p]];
          rd_pend_s[p] = pend_r[b][rd_addr_s[p]];
        end else begin
          rd_data_s[p] = rd_data_s[p];
          rd_pend_s[p] = rd_pend_s[p];
        end
      end
      if (is_zero_entry(rd_bank_s[p], rd_addr_s[p])) begin
        rd_data_s[p] = {DATA_WIDTH{1'b0}};
        rd_pend_s[p] = 1'b0;
      end else if ((BYPASS != 0) && wr_ok_s && (i_wr_bank == rd_bank_s[p]) &&
                   (i_wr_addr == rd_addr_s[p])) begin
        rd_data_s[p] = i_wr_data;
      end else begin
        rd_data_s[p] = rd_data_s[p];
      end
    end
  end

  assign o_rd_data_a = rd_data_s[0];
  assign o_rd_data_b = rd_data_s[1];
  assign o_pend_a    = rd_pend_s[0];
  assign o_pend_b    = rd_pend_s[1];
  assign o_clr_busy  = clr_busy_s;
  assign o_clr_done  = clr_done_s;

endmodule

// File: tb/tb_reg_file_mb.sv
// tb_reg_file_mb: directed self-checking bench for reg_file_mb.
// Built with BANK_W=2 so that bank code 2 is an illegal select.
module tb_reg_file_mb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_bank_a, rd_bank_b, wr_bank, pend_bank, clr_bank;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, pend_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data;
  logic        pend_a, pend_b, wr_en, pend_set, clr_req, clr_busy, clr_done;

  int n_vec;
  int n_err;

  reg_file_mb #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_BANKS  (2),
    .BANK_W     (2),
    .BYPASS     (1),
    .ZERO_REG0  (1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rd_bank_a (rd_bank_a),
    .i_rd_addr_a (rd_addr_a),
    .i_rd_bank_b (rd_bank_b),
    .i_rd_addr_b (rd_addr_b),
    .o_rd_data_a (rd_data_a),
    .o_rd_data_b (rd_data_b),
    .o_pend_a    (pend_a),
    .o_pend_b    (pend_b),
    .i_wr_en     (wr_en),
    .i_wr_bank   (wr_bank),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_pend_set  (pend_set),
    .i_pend_bank (pend_bank),
    .i_pend_addr (pend_addr),
    .i_clr_req   (clr_req),
    .i_clr_bank  (clr_bank),
    .o_clr_busy  (clr_busy),
    .o_clr_done  (clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] b, input logic [4:0] a,
                    input logic [31:0] d);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  // Read through port A mid-cycle and check data and pending.
  task automatic read_a(input string tag, input logic [1:0] b,
                        input logic [4:0] a, input logic [31:0] exp_d,
                        input logic exp_p);
    @(negedge clk);
    rd_bank_a = b; rd_addr_a = a;
    #1;
    check_vec({tag, "_data"}, rd_data_a, exp_d);
    check_vec({tag, "_pend"}, {31'd0, pend_a}, {31'd0, exp_p});
  endtask

  int busy_cnt;
  int done_cnt;
  int done_at;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    rd_bank_a = 2'd0; rd_addr_a = 5'd0; rd_bank_b = 2'd0; rd_addr_b = 5'd0;
    wr_en = 1'b0; wr_bank = 2'd0; wr_addr = 5'd0; wr_data = 32'd0;
    pend_set = 1'b0; pend_bank = 2'd0; pend_addr = 5'd0;
    clr_req = 1'b0; clr_bank = 2'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_busy", {31'd0, clr_busy}, 32'd0);
    check_vec("rst_done", {31'd0, clr_done}, 32'd0);
    rd_bank_a = 2'd1; rd_addr_a = 5'd7; #1;
    check_vec("rst_rd_a", rd_data_a, 32'd0);
    check_vec("rst_pend_a", {31'd0, pend_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Basic write / read on both banks
    wr(2'd1, 5'd7, 32'h3F80_0000);
    rd_bank_a = 2'd1; rd_addr_a = 5'd7; rd_bank_b = 2'd0; rd_addr_b = 5'd7; #1;
    check_vec("b1_7_a", rd_data_a, 32'h3F80_0000);
    check_vec("b0_7_b", rd_data_b, 32'd0);

    // Same-cycle forwarding, then stored value
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
    rd_bank_a = 2'd0; rd_addr_a = 5'd3; #1;
    check_vec("bypass_a", rd_data_a, 32'hDEAD_BEEF);
    cyc();
    wr_en = 1'b0; #1;
    check_vec("stored_b0_3", rd_data_a, 32'hDEAD_BEEF);

    // Hardwired zero entry: no forwarding, no store, no pending
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    pend_set = 1'b1; pend_bank = 2'd0; pend_addr = 5'd0;
    rd_bank_a = 2'd0; rd_addr_a = 5'd0; #1;
    check_vec("zero_bypass", rd_data_a, 32'd0);
    cyc();
    wr_en = 1'b0; pend_set = 1'b0;
    read_a("zero_after", 2'd0, 5'd0, 32'd0, 1'b0);

    // Pending set / clear-by-write / set-wins
    cyc();
    pend_set = 1'b1; pend_bank = 2'd0; pend_addr = 5'd5;
    rd_bank_a = 2'd0; rd_addr_a = 5'd5; #1;
    check_vec("pend_before", {31'd0, pend_a}, 32'd0);
    cyc();
    pend_set = 1'b0; #1;
    check_vec("pend_set", {31'd0, pend_a}, 32'd1);
    wr(2'd0, 5'd5, 32'h0000_0055);
    read_a("pend_wr_clr", 2'd0, 5'd5, 32'h0000_0055, 1'b0);
    cyc();
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 5'd5; wr_data = 32'h0000_A5A5;
    pend_set = 1'b1; pend_bank = 2'd0; pend_addr = 5'd5;
    cyc();
    wr_en = 1'b0; pend_set = 1'b0;
    read_a("set_wins", 2'd0, 5'd5, 32'h0000_A5A5, 1'b1);

    // Bulk clear of bank 1
    cyc();
    for (int i = 0; i < 32; i++) wr(2'd1, 5'(i), 32'(i + 1));
    wr(2'd0, 5'd9, 32'h0000_0900);
    clr_req = 1'b1; clr_bank = 2'd1;
    cyc();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      wr_en   = 1'b0;
      clr_req = (k == 10);
      clr_bank = 2'd0;
      if (k == 3) begin
        wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 5'd31; wr_data = 32'h0000_0BAD;
        rd_bank_a = 2'd1; rd_addr_a = 5'd31; #1;
        check_vec("clr_no_bypass", rd_data_a, 32'd32);
      end else if (k == 4) begin
        wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 5'd10; wr_data = 32'h0000_1010;
        rd_bank_a = 2'd1; rd_addr_a = 5'd20; rd_bank_b = 2'd1; rd_addr_b = 5'd0; #1;
        check_vec("clr_partial_0", rd_data_b, 32'd0);
        check_vec("clr_partial_20", rd_data_a, 32'd21);
      end
      cyc();
    end
    wr_en = 1'b0; clr_req = 1'b0;
    check_vec("clr_busy_cycles", 32'(busy_cnt), 32'd33);
    check_vec("clr_done_count", 32'(done_cnt), 32'd1);
    check_vec("clr_done_cycle", 32'(done_at), 32'd33);
    check_vec("clr_busy_end", {31'd0, clr_busy}, 32'd0);
    for (int i = 0; i < 32; i++) read_a("b1_cleared", 2'd1, 5'(i), 32'd0, 1'b0);
    read_a("b0_3_kept", 2'd0, 5'd3, 32'hDEAD_BEEF, 1'b0);
    read_a("b0_5_kept", 2'd0, 5'd5, 32'h0000_A5A5, 1'b1);
    read_a("b0_9_kept", 2'd0, 5'd9, 32'h0000_0900, 1'b0);
    read_a("b0_10_wr", 2'd0, 5'd10, 32'h0000_1010, 1'b0);

    // Reset in the middle of a clear
    cyc();
    wr(2'd1, 5'd30, 32'h0000_0030);
    wr(2'd0, 5'd12, 32'h0000_0012);
    clr_req = 1'b1; clr_bank = 2'd1;
    cyc();
    clr_req = 1'b0;
    repeat (9) cyc();
    check_vec("mid_busy_pre", {31'd0, clr_busy}, 32'd1);
    rst_n = 1'b0; #1;
    check_vec("mid_rst_busy", {31'd0, clr_busy}, 32'd0);
    check_vec("mid_rst_done", {31'd0, clr_done}, 32'd0);
    done_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (clr_done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (clr_done || clr_busy) done_cnt++;
    end
    check_vec("mid_rst_no_done", 32'(done_cnt), 32'd0);
    read_a("mid_b1_30", 2'd1, 5'd30, 32'd0, 1'b0);
    read_a("mid_b0_12", 2'd0, 5'd12, 32'd0, 1'b0);
    read_a("mid_b0_3", 2'd0, 5'd3, 32'd0, 1'b0);
    read_a("mid_b0_5", 2'd0, 5'd5, 32'd0, 1'b0);

    // Illegal bank select 2
    cyc();
    wr(2'd0, 5'd4, 32'h0000_0040);
    wr(2'd2, 5'd4, 32'h0000_0044);
    pend_set = 1'b1; pend_bank = 2'd2; pend_addr = 5'd4;
    cyc();
    pend_set = 1'b0;
    read_a("ill_rd", 2'd2, 5'd4, 32'd0, 1'b0);
    read_a("ill_no_alias", 2'd0, 5'd4, 32'h0000_0040, 1'b0);
    cyc();
    wr_en = 1'b1; wr_bank = 2'd2; wr_addr = 5'd4; wr_data = 32'h0000_0044;
    rd_bank_a = 2'd2; rd_addr_a = 5'd4; #1;
    check_vec("ill_no_bypass", rd_data_a, 32'd0);
    cyc();
    wr_en = 1'b0;
    clr_req = 1'b1; clr_bank = 2'd2;
    cyc();
    clr_req = 1'b0;
    check_vec("ill_clr_busy", {31'd0, clr_busy}, 32'd0);
    cyc();
    check_vec("ill_clr_busy2", {31'd0, clr_busy}, 32'd0);
    read_a("ill_clr_b0", 2'd0, 5'd4, 32'h0000_0040, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
